ccu_ar_snoop_router: RTL and testbench
======================================

// Module: ccu_ar_snoop_router
// PURPOSE
// Upstream of the read-snoop controller, per cached master. Decodes each AR (snoop, domain, bar)
//   into snoop_info_t, then steers it to one of three paths: SNP (read-snoop controller),
//   BYP (non-snooping, straight to memory) or ERR (local error responder).
// Merges R beats back to the master; an ID-agnostic outstanding counter prevents path mixing.
// PARAMETERS
// slv_req_t / slv_resp_t  logic  ACE req/resp types of the cached master port
// axi_req_t / axi_resp_t  logic  ACE req/resp types of SNP and BYP outputs (same AR/R payload)
// MaxTrans                4      max ARs in flight on the active path; counter width $clog2(MaxTrans+1)
// PORTS
// clk_i          in   1        clock
// rst_ni         in   1        asynchronous active-low reset
// slv_req_i      in   req_t    AR/R-ready from cached master; AW/W ignored
// slv_resp_o     out  resp_t   ar_ready, R channel to cached master; aw/w_ready, b_valid tied 0
// snp_req_o      out  req_t    AR + r_ready towards read-snoop controller
// snp_resp_i     in   resp_t   ar_ready + R from read-snoop controller
// snp_info_o     out  snoop_info_t  decode of snp_req_o.ar; valid whenever snp_req_o.ar_valid
// byp_req_o      out  req_t    AR + r_ready towards memory (non-snooping)
// byp_resp_i     in   resp_t   ar_ready + R from memory
// BEHAVIOUR
// Decode (comb., ar.bar[0]==0): snoop 4'b0000 & domain NonShareable/System -> BYP
//   ReadOnce(0000, Inner/Outer) -> SNP, snoop_trs=ReadOnce, accepts_dirty=0
//   ReadShared(0001) -> SNP, accepts_dirty=1;  ReadClean(0010) -> SNP, accepts_dirty=0
//   ReadNotSharedDirty(0011) -> SNP, accepts_dirty=0;  ReadUnique(0111) -> SNP, accepts_dirty=1
//   any other snoop code, or bar[0]==1 -> ERR
// Path lock: regs path_q (SNP/BYP/ERR, reset SNP), cnt_q (reset 0).
//   AR forwarded only if (cnt_q==0 || path_q==dec_path) && cnt_q<MaxTrans; else ar_ready=0,
//   no valid driven downstream. AR fields pass unmodified, zero added latency (comb. through).
//   AR handshake: path_q<=dec_path, cnt_q++; R last handshake on path_q: cnt_q--;
//   both same cycle -> cnt_q unchanged. cnt_q never wraps; MaxTrans reached -> stall.
// R merge: slv_resp_o.r/r_valid muxed from path_q only; r_ready routed back to that path only;
//   other paths' r_ready=0.
// ERR FSM: states IDLE -> ERR_R -> IDLE. IDLE: accept ERR AR (ar_ready=1 when lock allows),
//   latch id and len, beat counter=0. ERR_R: r_valid=1, r.id=latched id, r.data=0,
//   r.resp=2'b10 (SLVERR, [3:2]=0), r.last=(beat==len); beat++ on handshake; last
//   handshake -> IDLE. Only one ERR AR in flight; ERR AR blocked while ERR_R.
// Reset (any time, incl. mid-burst): all valids/readies 0, cnt_q=0, FSM IDLE, path_q=SNP;
//   in-flight downstream bursts are not recovered (system-wide reset assumed).
// slv_resp_o.ar_ready depends comb. on downstream ar_ready; no valid depends on ready.
// CONFIGURATION
// CCU_AR_ROUTER_STATS_EN defined: adds outputs stat_snp_o, stat_byp_o, stat_err_o (32b each,
//   reset 0), +1 on every AR handshake to that path, saturating at 32'hFFFF_FFFF.
// Not defined: ports and counters absent; all other behaviour identical.
// TESTING
// ReadShared len=3, Inner -> snp ar_valid same cycle, snp_info.accepts_dirty=1; 4 R beats pass.
// ReadNoSnoop NonShareable while 2 SNP ARs outstanding -> ar_ready=0 until 2nd SNP R last, then BYP.
// ReadUnique bar[0]=1 len=1 id=5 -> no downstream AR; 2 beats id=5 resp=SLVERR, last on beat 2.
// MaxTrans=4: 5 back-to-back ReadOnce, no R -> 5th stalls; one R last -> 5th accepted next cycle.
// R last and new same-path AR in same cycle -> cnt_q unchanged; r_ready backpressure holds beats.
// Reset asserted mid ERR_R beat -> r_valid=0 immediately; post-reset ReadOnce forwarded at once.

Source files
------------

// File: rtl/ccu_ar_snoop_router.sv
// ccu_ar_snoop_router: per-master AR decode and steering to SNP / BYP / ERR paths,
// with R-beat merge back to the cached master.
// An ID-agnostic outstanding counter locks the active path so responses never interleave.
// Optional feature macro: CCU_AR_ROUTER_STATS_EN adds saturating per-path AR counters.

package ccu_ar_snoop_router_pkg;
  localparam int unsigned IdW  = 4;
  localparam int unsigned LenW = 8;

  localparam logic [1:0] DOM_NSH   = 2'b00;
  localparam logic [1:0] DOM_INNER = 2'b01;
  localparam logic [1:0] DOM_OUTER = 2'b10;
  localparam logic [1:0] DOM_SYS   = 2'b11;

  typedef struct packed {
    logic [IdW-1:0]  id;
    logic [31:0]     addr;
    logic [LenW-1:0] len;
    logic [2:0]      size;
    logic [1:0]      burst;
    logic [1:0]      domain;
    logic [3:0]      snoop;
    logic [1:0]      bar;
  } ar_chan_t;

  typedef struct packed {
    logic [IdW-1:0] id;
    logic [63:0]    data;
    logic [3:0]     resp;
    logic           last;
  } r_chan_t;

  typedef struct packed {
    logic     aw_valid;
    logic     w_valid;
    logic     b_ready;
    ar_chan_t ar;
    logic     ar_valid;
    logic     r_ready;
  } req_t;

  typedef struct packed {
    logic    aw_ready;
    logic    w_ready;
    logic    b_valid;
    logic    ar_ready;
    r_chan_t r;
    logic    r_valid;
  } resp_t;

  typedef struct packed {
    logic [3:0] snoop_trs;
    logic       accepts_dirty;
  } snoop_info_t;

  typedef enum logic [1:0] {PATH_SNP = 2'd0, PATH_BYP = 2'd1, PATH_ERR = 2'd2} path_e;
endpackage

module ccu_ar_snoop_router
  import ccu_ar_snoop_router_pkg::*;
#(
  parameter int unsigned MaxTrans = 4,
  parameter type slv_req_t  = req_t,
  parameter type slv_resp_t = resp_t,
  parameter type axi_req_t  = req_t,
  parameter type axi_resp_t = resp_t
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  slv_req_t    slv_req_i,
  output slv_resp_t   slv_resp_o,
  output axi_req_t    snp_req_o,
  input  axi_resp_t   snp_resp_i,
  output snoop_info_t snp_info_o,
  output axi_req_t    byp_req_o,
  input  axi_resp_t   byp_resp_i
`ifdef CCU_AR_ROUTER_STATS_EN
  ,
  output logic [31:0] stat_snp_o,
  output logic [31:0] stat_byp_o,
  output logic [31:0] stat_err_o
`endif
);

  localparam int unsigned     CntW   = $clog2(MaxTrans + 1);
  localparam logic [CntW-1:0] CntMax = CntW'(MaxTrans);

  typedef enum logic {ERR_IDLE, ERR_R} err_state_e;

  path_e           dec_path, path_q;
  snoop_info_t     dec_info;
  logic [CntW-1:0] cnt_q;
  err_state_e      state_q, state_d;
  logic [IdW-1:0]  err_id_q;
  logic [LenW-1:0] err_len_q, beat_q;
  logic            lock_ok, ar_hs, r_last_hs, err_ar_hs, err_r_hs, err_r_valid;
  logic            unused_in;

  // AW/W/B are not part of this block; keep them visibly consumed.
  assign unused_in = ^{slv_req_i.aw_valid, slv_req_i.w_valid, slv_req_i.b_ready,
                       snp_resp_i.aw_ready, snp_resp_i.w_ready, snp_resp_i.b_valid,
                       byp_resp_i.aw_ready, byp_resp_i.w_ready, byp_resp_i.b_valid};

  // Decode the incoming AR into a destination path and snoop info
  always_comb begin
    dec_path = PATH_ERR;
    dec_info = '0;
    dec_info.snoop_trs = slv_req_i.ar.snoop;
    if (!slv_req_i.ar.bar[0]) begin
      case (slv_req_i.ar.snoop)
        4'b0000: begin
          if (slv_req_i.ar.domain == DOM_NSH || slv_req_i.ar.domain == DOM_SYS)
            dec_path = PATH_BYP;
          else
            dec_path = PATH_SNP;
        end
        4'b0001, 4'b0111: begin
          dec_path               = PATH_SNP;
          dec_info.accepts_dirty = 1'b1;
        end
        4'b0010, 4'b0011: dec_path = PATH_SNP;
        default:          dec_path = PATH_ERR;
      endcase
    end
  end

  assign snp_info_o = dec_info;

  // A new AR may only join the path already in flight, and never beyond MaxTrans.
  assign lock_ok = rst_ni && (cnt_q == '0 || path_q == dec_path) && (cnt_q < CntMax);

  // AR steering and R merge; everything not explicitly routed stays 0
  always_comb begin
    snp_req_o  = '0;
    byp_req_o  = '0;
    slv_resp_o = '0;
    snp_req_o.ar       = slv_req_i.ar;
    byp_req_o.ar       = slv_req_i.ar;
    snp_req_o.ar_valid = slv_req_i.ar_valid && lock_ok && dec_path == PATH_SNP;
    byp_req_o.ar_valid = slv_req_i.ar_valid && lock_ok && dec_path == PATH_BYP;
    case (dec_path)
      PATH_SNP: slv_resp_o.ar_ready = lock_ok && snp_resp_i.ar_ready;
      PATH_BYP: slv_resp_o.ar_ready = lock_ok && byp_resp_i.ar_ready;
      default:  slv_resp_o.ar_ready = lock_ok && state_q == ERR_IDLE;
    endcase
    case (path_q)
      PATH_SNP: begin
        slv_resp_o.r       = snp_resp_i.r;
        slv_resp_o.r_valid = snp_resp_i.r_valid;
        snp_req_o.r_ready  = slv_req_i.r_ready;
      end
      PATH_BYP: begin
        slv_resp_o.r       = byp_resp_i.r;
        slv_resp_o.r_valid = byp_resp_i.r_valid;
        byp_req_o.r_ready  = slv_req_i.r_ready;
      end
      default: begin
        slv_resp_o.r.id    = err_id_q;
        slv_resp_o.r.resp  = 4'b0010;
        slv_resp_o.r.last  = (beat_q == err_len_q);
        slv_resp_o.r_valid = err_r_valid;
      end
    endcase
    if (!rst_ni) begin
      slv_resp_o.r_valid = 1'b0;
      snp_req_o.r_ready  = 1'b0;
      byp_req_o.r_ready  = 1'b0;
    end
  end

  assign ar_hs     = slv_req_i.ar_valid && slv_resp_o.ar_ready;
  assign r_last_hs = slv_resp_o.r_valid && slv_req_i.r_ready && slv_resp_o.r.last;
  assign err_ar_hs = ar_hs && dec_path == PATH_ERR;
  assign err_r_hs  = err_r_valid && slv_req_i.r_ready;

  // Path lock and outstanding counter; simultaneous AR and R-last cancel out
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      path_q <= PATH_SNP;
      cnt_q  <= '0;
    end else begin
      if (ar_hs) path_q <= dec_path;
      if (ar_hs && !r_last_hs)
        cnt_q <= cnt_q + CntW'(1);
      else if (!ar_hs && r_last_hs && cnt_q != '0)
        cnt_q <= cnt_q - CntW'(1);
    end
  end

  // Error responder state register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= ERR_IDLE;
    else         state_q <= state_d;
  end

  // Error responder next state: one burst of SLVERR beats per accepted ERR AR
  always_comb begin
    state_d     = state_q;
    err_r_valid = 1'b0;
    case (state_q)
      ERR_IDLE: if (err_ar_hs) state_d = ERR_R;
      ERR_R: begin
        err_r_valid = 1'b1;
        if (err_r_hs && beat_q == err_len_q) state_d = ERR_IDLE;
      end
      default: state_d = ERR_IDLE;
    endcase
  end

  // Error responder burst bookkeeping
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      err_id_q  <= '0;
      err_len_q <= '0;
      beat_q    <= '0;
    end else if (err_ar_hs) begin
      err_id_q  <= slv_req_i.ar.id;
      err_len_q <= slv_req_i.ar.len;
      beat_q    <= '0;
    end else if (err_r_hs) begin
      beat_q <= beat_q + LenW'(1);
    end
  end

`ifdef CCU_AR_ROUTER_STATS_EN
  // Per-path AR handshake counters, saturating at all-ones
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      stat_snp_o <= '0;
      stat_byp_o <= '0;
      stat_err_o <= '0;
    end else if (ar_hs) begin
      case (dec_path)
        PATH_SNP: if (stat_snp_o != '1) stat_snp_o <= stat_snp_o + 32'd1;
        PATH_BYP: if (stat_byp_o != '1) stat_byp_o <= stat_byp_o + 32'd1;
        default:  if (stat_err_o != '1) stat_err_o <= stat_err_o + 32'd1;
      endcase
    end
  end
`endif

endmodule

// File: tb/tb_ccu_ar_snoop_router.sv
// Directed bench for ccu_ar_snoop_router: decode, path lock, R merge, error responder, reset.
module tb_ccu_ar_snoop_router;
  import ccu_ar_snoop_router_pkg::*;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  req_t        slv_req;
  resp_t       slv_resp;
  req_t        snp_req;
  resp_t       snp_resp;
  snoop_info_t snp_info;
  req_t        byp_req;
  resp_t       byp_resp;
`ifdef CCU_AR_ROUTER_STATS_EN
  logic [31:0] stat_snp, stat_byp, stat_err;
`endif

  int n_cmp = 0;
  int n_err = 0;

  // decode table: snoop, domain, expected snp valid, byp valid, accepts_dirty
  logic [3:0] t_snoop [6] = '{4'b0000, 4'b0000, 4'b0000, 4'b0010, 4'b0011, 4'b0111};
  logic [1:0] t_dom   [6] = '{DOM_NSH, DOM_SYS, DOM_OUTER, DOM_INNER, DOM_INNER, DOM_INNER};
  logic       t_snp   [6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
  logic       t_byp   [6] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
  logic       t_dirty [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

  ccu_ar_snoop_router dut (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .slv_req_i  (slv_req),
    .slv_resp_o (slv_resp),
    .snp_req_o  (snp_req),
    .snp_resp_i (snp_resp),
    .snp_info_o (snp_info),
    .byp_req_o  (byp_req),
    .byp_resp_i (byp_resp)
`ifdef CCU_AR_ROUTER_STATS_EN
    ,
    .stat_snp_o (stat_snp),
    .stat_byp_o (stat_byp),
    .stat_err_o (stat_err)
`endif
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  function automatic ar_chan_t mk_ar(input logic [3:0] id, input logic [7:0] len,
                                     input logic [3:0] snoop, input logic [1:0] dom,
                                     input logic [1:0] bar);
    ar_chan_t a;
    a        = '0;
    a.id     = id;
    a.addr   = 32'h0000_1000 + {28'd0, id};
    a.len    = len;
    a.size   = 3'd3;
    a.burst  = 2'b01;
    a.domain = dom;
    a.snoop  = snoop;
    a.bar    = bar;
    return a;
  endfunction

  function automatic r_chan_t mk_r(input logic [3:0] id, input logic [63:0] data, input logic last);
    r_chan_t r;
    r      = '0;
    r.id   = id;
    r.data = data;
    r.last = last;
    return r;
  endfunction

  initial begin
    // ---- reset: nothing may be valid or ready while held
    rst_ni   = 1'b0;
    slv_req  = '0;
    snp_resp = '0;
    byp_resp = '0;
    slv_req.ar        = mk_ar(4'd1, 8'd0, 4'b0000, DOM_INNER, 2'b00);
    slv_req.ar_valid  = 1'b1;
    snp_resp.ar_ready = 1'b1;
    snp_resp.r_valid  = 1'b1;
    #3;
    chk("rst_snp_ar_valid", snp_req.ar_valid, 1'b0);
    chk("rst_slv_ar_ready", slv_resp.ar_ready, 1'b0);
    chk("rst_slv_r_valid", slv_resp.r_valid, 1'b0);
    slv_req  = '0;
    snp_resp = '0;
    tick(); tick();
    rst_ni = 1'b1;
    snp_resp.ar_ready = 1'b1;
    byp_resp.ar_ready = 1'b1;
    tick();

    // ---- ReadShared len=3 Inner: forwarded same cycle, 4 beats merged back
    slv_req.ar       = mk_ar(4'd1, 8'd3, 4'b0001, DOM_INNER, 2'b00);
    slv_req.ar_valid = 1'b1;
    settle();
    chk("rs_snp_valid", snp_req.ar_valid, 1'b1);
    chk("rs_byp_valid", byp_req.ar_valid, 1'b0);
    chk("rs_dirty", snp_info.accepts_dirty, 1'b1);
    chk("rs_trs", snp_info.snoop_trs, 4'b0001);
    chk("rs_ar_pass", snp_req.ar, mk_ar(4'd1, 8'd3, 4'b0001, DOM_INNER, 2'b00));
    chk("rs_ar_ready", slv_resp.ar_ready, 1'b1);
    tick();
    slv_req.ar_valid = 1'b0;
    slv_req.r_ready  = 1'b1;
    for (int k = 0; k < 4; k++) begin
      snp_resp.r_valid = 1'b1;
      snp_resp.r       = mk_r(4'd1, 64'hA0 + 64'(k), k == 3);
      settle();
      chk("rs_r_valid", slv_resp.r_valid, 1'b1);
      chk("rs_r_data", slv_resp.r.data, 64'hA0 + 64'(k));
      chk("rs_r_last", slv_resp.r.last, k == 3);
      chk("rs_snp_r_ready", snp_req.r_ready, 1'b1);
      chk("rs_byp_r_ready", byp_req.r_ready, 1'b0);
      tick();
    end
    snp_resp.r_valid = 1'b0;

    // ---- decode table with downstream not ready (no handshakes)
    snp_resp.ar_ready = 1'b0;
    byp_resp.ar_ready = 1'b0;
    slv_req.ar_valid  = 1'b1;
    for (int i = 0; i < 6; i++) begin
      slv_req.ar = mk_ar(4'd2, 8'd0, t_snoop[i], t_dom[i], 2'b00);
      settle();
      chk("dec_snp_valid", snp_req.ar_valid, t_snp[i]);
      chk("dec_byp_valid", byp_req.ar_valid, t_byp[i]);
      chk("dec_dirty", snp_info.accepts_dirty, t_dirty[i]);
      chk("dec_no_ready", slv_resp.ar_ready, 1'b0);
    end
    slv_req.ar_valid  = 1'b0;
    snp_resp.ar_ready = 1'b1;
    byp_resp.ar_ready = 1'b1;
    tick();

    // ---- ReadNoSnoop blocked while 2 SNP ARs outstanding
    slv_req.ar       = mk_ar(4'd2, 8'd0, 4'b0000, DOM_INNER, 2'b00);
    slv_req.ar_valid = 1'b1;
    tick();
    slv_req.ar = mk_ar(4'd3, 8'd0, 4'b0000, DOM_INNER, 2'b00);
    tick();
    slv_req.ar = mk_ar(4'd4, 8'd0, 4'b0000, DOM_NSH, 2'b00);
    settle();
    chk("byp_blk_ready", slv_resp.ar_ready, 1'b0);
    chk("byp_blk_valid", byp_req.ar_valid, 1'b0);
    snp_resp.r_valid = 1'b1;
    snp_resp.r       = mk_r(4'd2, 64'h1, 1'b1);
    tick();
    snp_resp.r = mk_r(4'd3, 64'h2, 1'b1);
    settle();
    chk("byp_blk_ready2", slv_resp.ar_ready, 1'b0);
    tick();
    snp_resp.r_valid = 1'b0;
    settle();
    chk("byp_go_valid", byp_req.ar_valid, 1'b1);
    chk("byp_go_ready", slv_resp.ar_ready, 1'b1);
    tick();
    slv_req.ar_valid = 1'b0;
    snp_resp.r_valid = 1'b1;
    snp_resp.r       = mk_r(4'd9, 64'hDEAD, 1'b1);
    settle();
    chk("byp_no_snp_leak", slv_resp.r_valid, 1'b0);
    chk("byp_snp_r_ready", snp_req.r_ready, 1'b0);
    byp_resp.r_valid = 1'b1;
    byp_resp.r       = mk_r(4'd4, 64'hB0, 1'b1);
    settle();
    chk("byp_r_data", slv_resp.r.data, 64'hB0);
    chk("byp_r_ready", byp_req.r_ready, 1'b1);
    tick();
    byp_resp.r_valid = 1'b0;
    snp_resp.r_valid = 1'b0;

    // ---- ReadUnique with bar[0]=1, len=1, id=5 -> local SLVERR burst
    slv_req.ar       = mk_ar(4'd5, 8'd1, 4'b0111, DOM_INNER, 2'b01);
    slv_req.ar_valid = 1'b1;
    settle();
    chk("err_no_snp", snp_req.ar_valid, 1'b0);
    chk("err_no_byp", byp_req.ar_valid, 1'b0);
    chk("err_ar_ready", slv_resp.ar_ready, 1'b1);
    tick();
    slv_req.r_ready = 1'b0;
    settle();
    chk("err_one_inflight", slv_resp.ar_ready, 1'b0);
    slv_req.ar_valid = 1'b0;
    chk("err_b0_valid", slv_resp.r_valid, 1'b1);
    chk("err_b0_id", slv_resp.r.id, 4'd5);
    chk("err_b0_resp", slv_resp.r.resp, 4'b0010);
    chk("err_b0_data", slv_resp.r.data, 64'd0);
    chk("err_b0_last", slv_resp.r.last, 1'b0);
    chk("tie_aw_ready", slv_resp.aw_ready, 1'b0);
    chk("tie_b_valid", slv_resp.b_valid, 1'b0);
    tick();
    chk("err_hold_last", slv_resp.r.last, 1'b0);
    slv_req.r_ready = 1'b1;
    tick();
    chk("err_b1_valid", slv_resp.r_valid, 1'b1);
    chk("err_b1_last", slv_resp.r.last, 1'b1);
    chk("err_b1_id", slv_resp.r.id, 4'd5);
    tick();
    chk("err_done", slv_resp.r_valid, 1'b0);

    // ---- MaxTrans=4: 5 ReadOnce back-to-back, 5th stalls until one R last
    slv_req.ar       = mk_ar(4'd8, 8'd0, 4'b0000, DOM_INNER, 2'b00);
    slv_req.ar_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      settle();
      chk("mt_accept", slv_resp.ar_ready, 1'b1);
      tick();
    end
    chk("mt_stall_ready", slv_resp.ar_ready, 1'b0);
    chk("mt_stall_valid", snp_req.ar_valid, 1'b0);
    snp_resp.r_valid = 1'b1;
    snp_resp.r       = mk_r(4'd8, 64'h5, 1'b1);
    settle();
    chk("mt_stall_during_r", slv_resp.ar_ready, 1'b0);
    tick();
    snp_resp.r_valid = 1'b0;
    settle();
    chk("mt_5th_accept", slv_resp.ar_ready, 1'b1);
    tick();

    // ---- same-cycle R last and same-path AR leave the count unchanged (3 -> 3)
    slv_req.ar_valid = 1'b0;
    snp_resp.r_valid = 1'b1;
    tick();
    slv_req.ar_valid = 1'b1;
    settle();
    chk("sim_accept", slv_resp.ar_ready, 1'b1);
    tick();
    snp_resp.r_valid = 1'b0;
    settle();
    chk("sim_after", slv_resp.ar_ready, 1'b1);
    tick();
    chk("sim_full", slv_resp.ar_ready, 1'b0);
    slv_req.ar_valid = 1'b0;

    // ---- r_ready backpressure holds the beat, then drain all 4
    snp_resp.r_valid = 1'b1;
    slv_req.r_ready  = 1'b0;
    settle();
    chk("bp_snp_r_ready", snp_req.r_ready, 1'b0);
    chk("bp_r_valid", slv_resp.r_valid, 1'b1);
    tick();
    slv_req.r_ready = 1'b1;
    repeat (4) tick();
    snp_resp.r_valid = 1'b0;

    // ---- reset mid ERR_R beat, then ReadOnce forwarded at once
    slv_req.ar       = mk_ar(4'd6, 8'd3, 4'b1000, DOM_INNER, 2'b00);
    slv_req.ar_valid = 1'b1;
    settle();
    chk("rst2_err_accept", slv_resp.ar_ready, 1'b1);
    tick();
    slv_req.ar_valid = 1'b0;
    settle();
    chk("rst2_err_rvalid", slv_resp.r_valid, 1'b1);
    rst_ni = 1'b0;
    settle();
    chk("rst2_rvalid_low", slv_resp.r_valid, 1'b0);
    chk("rst2_ar_ready_low", slv_resp.ar_ready, 1'b0);
    tick();
    rst_ni           = 1'b1;
    slv_req.ar       = mk_ar(4'd7, 8'd0, 4'b0000, DOM_INNER, 2'b00);
    slv_req.ar_valid = 1'b1;
    settle();
    chk("post_rst_snp_valid", snp_req.ar_valid, 1'b1);
    chk("post_rst_ar_ready", slv_resp.ar_ready, 1'b1);
    chk("post_rst_r_valid", slv_resp.r_valid, 1'b0);
    tick();
    slv_req.ar_valid = 1'b0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
